// File: rtl/addsh_arbiter.sv
// addsh_arbiter: round-robin arbiter in front of a shared add-then-shift datapath.
// Two requesters submit {op1, op2, sel}. The block adds the operands with carry,
// shifts the sum right by 0/1/2/5 and returns the result tagged with the requester id.
// Optional feature: define ADDSH_FASTPATH_EN to let sel==00 operations skip SHIFT
// and respond straight from ADD.
module addsh_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [1:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_data
);

    localparam int unsigned RES_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [WIDTH-1:0]   op1_r;
    logic [WIDTH-1:0]   op1_d;
    logic [WIDTH-1:0]   op2_r;
    logic [WIDTH-1:0]   op2_d;
    logic [1:0]         sel_r;
    logic [1:0]         sel_d;
    logic               id_r;
    logic               id_d;
    logic               last_grant;
    logic               last_grant_d;
    logic [RES_W-1:0]   sum_r;
    logic [RES_W-1:0]   sum_d;
    logic [RES_W-1:0]   sum_add;
    logic [RES_W-1:0]   shifted;
    logic               rsp_valid_d;
    logic               rsp_id_d;
    logic [RES_W-1:0]   rsp_data_d;
    logic               grant_any;
    logic               grant_id;

    // Round-robin pick: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_any = (state == IDLE) && (req0_valid || req1_valid);
        grant_id  = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
    end

    // Ready is offered only to the granted requester, and never while reset is asserted.
    always_comb begin
        req0_ready = rst_n && grant_any && !grant_id;
        req1_ready = rst_n && grant_any && grant_id;
    end

    // Full-width add; the top bit carries out so no sum can overflow.
    always_comb begin
        sum_add = {1'b0, op1_r} + {1'b0, op2_r};
    end

    // Logical right shift selected by the latched sel code (00/01/10/11 -> 0/1/2/5).
    always_comb begin
        case (sel_r)
            2'b00:   shifted = sum_r;
            2'b01:   shifted = sum_r >> 1;
            2'b10:   shifted = sum_r >> 2;
            default: shifted = sum_r >> 5;
        endcase
    end

    // Next-state and datapath control for IDLE -> ADD -> SHIFT -> RESP.
    always_comb begin
        state_d      = state;
        op1_d        = op1_r;
        op2_d        = op2_r;
        sel_d        = sel_r;
        id_d         = id_r;
        last_grant_d = last_grant;
        sum_d        = sum_r;
        rsp_valid_d  = rsp_valid;
        rsp_id_d     = rsp_id;
        rsp_data_d   = rsp_data;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    op1_d        = grant_id ? req1_op1 : req0_op1;
                    op2_d        = grant_id ? req1_op2 : req0_op2;
                    sel_d        = grant_id ? req1_sel : req0_sel;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ADD;
                end
            end
            ADD: begin
                sum_d   = sum_add;
                state_d = SHIFT;
`ifdef ADDSH_FASTPATH_EN
                if (sel_r == 2'b00) begin
                    rsp_data_d  = sum_add;
                    rsp_id_d    = id_r;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`endif
            end
            SHIFT: begin
                rsp_data_d  = shifted;
                rsp_id_d    = id_r;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op1_r      <= '0;
            op2_r      <= '0;
            sel_r      <= '0;
            id_r       <= 1'b0;
            last_grant <= 1'b1;
            sum_r      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state      <= state_d;
            op1_r      <= op1_d;
            op2_r      <= op2_d;
            sel_r      <= sel_d;
            id_r       <= id_d;
            last_grant <= last_grant_d;
            sum_r      <= sum_d;
            rsp_valid  <= rsp_valid_d;
            rsp_id     <= rsp_id_d;
            rsp_data   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_addsh_arbiter.sv
// Bench for addsh_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Honours ADDSH_FASTPATH_EN for the expected sel==00 latency.
module tb_addsh_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_op1 = '0;
    logic [W-1:0] req0_op2 = '0;
    logic [1:0]   req0_sel = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_op1 = '0;
    logic [W-1:0] req1_op2 = '0;
    logic [1:0]   req1_sel = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [W:0]   rsp_data;

    addsh_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result straight from the arithmetic rule: (a + b) >> k, k in {0,1,2,5}.
    function automatic logic [8:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
        int sum;
        int k;
        sum = int'(a) + int'(b);
        k   = (s == 2'd3) ? 5 : int'(s);
        return 9'(sum >> k);
    endfunction

    // Edges from acceptance to rsp_valid.
    function automatic int exp_lat(input logic [1:0] s);
`ifdef ADDSH_FASTPATH_EN
        return (s == 2'd0) ? 2 : 3;
`else
        return (s == 2'd0) ? 3 : 3;
`endif
    endfunction

    // Transaction model: busy flag, cycles left until the response, pending response.
    bit       m_busy = 1'b0;
    bit       m_rv   = 1'b0;
    bit       m_rid  = 1'b0;
    bit       m_last = 1'b1;
    bit       m_pid  = 1'b0;
    int       m_cnt  = 0;
    logic [8:0] m_rd    = '0;
    logic [8:0] m_pdata = '0;
    logic     g_any;
    logic     g_id;

    always_comb begin
        g_any = rst_n && !m_busy && (req0_valid || req1_valid);
        g_id  = (req0_valid && req1_valid) ? !m_last : !req0_valid;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_rid  <= 1'b0;
            m_rd   <= '0;
            m_last <= 1'b1;
            m_cnt  <= 0;
        end else if (m_rv) begin
            if (rsp_ready) begin
                m_rv   <= 1'b0;
                m_busy <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_rv  <= 1'b1;
                m_rd  <= m_pdata;
                m_rid <= m_pid;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (g_any) begin
            m_busy  <= 1'b1;
            m_last  <= g_id;
            m_pid   <= g_id;
            m_pdata <= g_id ? ref_res(req1_op1, req1_op2, req1_sel)
                            : ref_res(req0_op1, req0_op2, req0_sel);
            m_cnt   <= exp_lat(g_id ? req1_sel : req0_sel) - 1;
        end
    end

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        check("req0_ready", 32'(req0_ready), 32'(g_any && !g_id));
        check("req1_ready", 32'(req1_ready), 32'(g_any && g_id));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            check("rsp_data", 32'(rsp_data), 32'(m_rd));
            check("rsp_id", 32'(rsp_id), 32'(m_rid));
        end
    end

    task automatic drive(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] s);
        if (id) begin
            req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_sel = s;
        end else begin
            req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_sel = s;
        end
    endtask

    // Wait for the grant of one requester, then drop its valid after the accepting edge.
    task automatic wait_ready(input bit id, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) seen = 1'b1;
        end
        check({name, "_granted"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Wait for a response (rsp_ready assumed high) and check it against literals.
    task automatic wait_rsp(input string name, input bit exp_id, input logic [8:0] exp_data,
                            input int exp_cycles);
        bit seen = 1'b0;
        int n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({name, "_id"}, 32'(rsp_id), 32'(exp_id));
        if (exp_cycles > 0) check({name, "_latency"}, 32'(n), 32'(exp_cycles));
        @(posedge clk); #1;
    endtask

    task automatic drain(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [8:0] exp_c_data [4];
    bit         exp_c_id   [4];
    bit         a0;
    bit         a1;

    initial begin
        exp_c_data = '{9'h110, 9'h0FF, 9'h110, 9'h0FF};
        exp_c_id   = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single op and shift sweep from requester 0
        drive(1'b0, 8'hF0, 8'h20, 2'b00);
        wait_ready(1'b0, "single");
`ifdef ADDSH_FASTPATH_EN
        wait_rsp("single", 1'b0, 9'h110, 2);
`else
        wait_rsp("single", 1'b0, 9'h110, 3);
`endif
        drive(1'b0, 8'hF0, 8'h20, 2'b01);
        wait_ready(1'b0, "sweep01");
        wait_rsp("sweep01", 1'b0, 9'h088, 3);
        drive(1'b0, 8'hF0, 8'h20, 2'b10);
        wait_ready(1'b0, "sweep10");
        wait_rsp("sweep10", 1'b0, 9'h044, 3);
        drive(1'b0, 8'hF0, 8'h20, 2'b11);
        wait_ready(1'b0, "sweep11");
        wait_rsp("sweep11", 1'b0, 9'h008, 3);

        // Contention from reset: both held valid, grants alternate starting with 0
        rst_n = 1'b0;
        drive(1'b0, 8'hF0, 8'h20, 2'b00);
        drive(1'b1, 8'hFF, 8'hFF, 2'b01);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp($sformatf("contend%0d", k), exp_c_id[k], exp_c_data[k], 0);
        end

        // Backpressure on the fifth response
        rsp_ready = 1'b0;
        wait_rsp("bp_first", 1'b0, 9'h110, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'h110);
            check("bp_id", 32'(rsp_id), 32'd0);
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_next_grant1", 32'(req1_ready), 32'd1);
        drain(8);

        // Reset during SHIFT: immediate clear, stale op dropped, requester 0 wins next
        drive(1'b0, 8'h10, 8'h20, 2'b01);
        wait_ready(1'b0, "rst_op");
        drive(1'b0, 8'h33, 8'h11, 2'b00);
        drive(1'b1, 8'h01, 8'h01, 2'b11);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant0", 32'(req0_ready), 32'd1);
        check("rst_first_grant1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_rsp("rst_after0", 1'b0, 9'h044, 0);
        wait_ready(1'b1, "rst_after1");
        wait_rsp("rst_after1", 1'b1, 9'h000, 0);
        drain(4);

        // Late request from requester 1 while ADD is running
        drive(1'b0, 8'h01, 8'h02, 2'b00);
        wait_ready(1'b0, "late0");
        drive(1'b1, 8'h12, 8'h34, 2'b10);
        @(negedge clk);
        check("late_ready1_in_add", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        wait_rsp("late0", 1'b0, 9'h003, 0);
        wait_ready(1'b1, "late1");
        wait_rsp("late1", 1'b1, 9'h011, 0);
        drain(4);

        // Randomized traffic, compared cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || a0) begin
                if ($urandom_range(0, 2) == 0)
                    drive(1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
                else
                    req0_valid = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || a1) begin
                if ($urandom_range(0, 2) == 0)
                    drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
                else
                    req1_valid = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
